// File: rtl/coin_if.sv
// Accepted-coin handshake between the coin acceptor and the vending controller.
interface coin_if;
  logic       coin_valid;
  logic       coin_ready;
  logic [3:0] coin_insert;
  logic [7:0] coin_cents;

  modport master (output coin_valid, output coin_insert, output coin_cents, input coin_ready);
  modport slave  (input coin_valid, input coin_insert, input coin_cents, output coin_ready);
endinterface

// File: rtl/coin_acceptor.sv
// Coin-slot front end: sync + debounce four sensor lanes, classify, detect faults,
// and buffer accepted coins for the vending controller.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 1000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [3:0]                    coin_sense,
  input  logic                          accept_en,
  input  logic                          jam_clear,
  output logic                          coin_return,
  output logic                          jam_error,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  coin_if.master                        coin
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0]    DEB      = DEBOUNCE_CYCLES[7:0];
  localparam logic [16:0]   JAM      = {1'b0, JAM_CYCLES[15:0]};
  localparam logic [AW:0]   FULL     = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RISE, HELD, FALL} deb_state_t;

  function automatic logic [1:0] lane_of(input logic [3:0] onehot);
    lane_of = 2'd0;
    for (int i = 0; i < 4; i++)
      if (onehot[i]) lane_of = 2'(i);
  endfunction

  function automatic logic [7:0] cents_of(input logic [1:0] lane);
    case (lane)
      2'd0:    cents_of = 8'd10;
      2'd1:    cents_of = 8'd20;
      2'd2:    cents_of = 8'd50;
      default: cents_of = 8'd100;
    endcase
  endfunction

  logic [3:0]   sync_p0, sync_p1, evt_p2;
  deb_state_t   state [4];
  logic [7:0]   cnt [4];
  logic [16:0]  jam_cnt;
  logic [1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [AW:0]  count_next;
  logic [1:0]   new_lane;
  logic         any_evt, multi, full, refuse, push, pop;

  // Stage p0/p1: two-flop synchroniser; stage p2: per-lane debounce and qualify event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      evt_p2  <= '0;
      for (int i = 0; i < 4; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      sync_p0 <= coin_sense;
      sync_p1 <= sync_p0;
      for (int i = 0; i < 4; i++) begin
        evt_p2[i] <= 1'b0;
        case (state[i])
          IDLE: begin
            cnt[i] <= '0;
            if (sync_p1[i]) begin
              state[i] <= RISE;
              cnt[i]   <= 8'd1;
            end
          end
          RISE: begin
            if (!sync_p1[i]) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else if (cnt[i] + 8'd1 == DEB) begin
              state[i]  <= HELD;
              cnt[i]    <= '0;
              evt_p2[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + 8'd1;
            end
          end
          HELD: begin
            if (!sync_p1[i]) begin
              state[i] <= FALL;
              cnt[i]   <= 8'd1;
            end
          end
          FALL: begin
            if (sync_p1[i]) begin
              state[i] <= HELD;
              cnt[i]   <= '0;
            end else if (cnt[i] + 8'd1 == DEB) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else begin
              cnt[i] <= cnt[i] + 8'd1;
            end
          end
          default: begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  // Jam watch runs on the synchronised lanes; the counter saturates once the fault is set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jam_cnt   <= '0;
      jam_error <= 1'b0;
    end else if (|sync_p1) begin
      if (jam_cnt + 17'd1 >= JAM) begin
        jam_cnt   <= JAM;
        jam_error <= 1'b1;
      end else begin
        jam_cnt <= jam_cnt + 17'd1;
      end
    end else begin
      jam_cnt <= '0;
      if (jam_clear) jam_error <= 1'b0;
    end
  end

  // More than one bit set in the event vector means coins arrived together.
  assign any_evt  = |evt_p2;
  assign multi    = |(evt_p2 & (evt_p2 - 4'd1));
  assign full     = (fifo_count == FULL);
  assign refuse   = any_evt && (multi || !accept_en || jam_error || full);
  assign push     = any_evt && !refuse;
  assign pop      = coin.coin_valid && coin.coin_ready;
  assign new_lane = lane_of(evt_p2);
  assign rd_next  = rd_ptr + PTR_ONE;

  always_comb begin
    count_next = fifo_count;
    if (push && !pop)      count_next = fifo_count + CNT_ONE;
    else if (pop && !push) count_next = fifo_count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_lane;
  end

  // Stage p3: FIFO control and registered head-of-queue presentation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_count       <= '0;
      coin_return      <= 1'b0;
      coin.coin_valid  <= 1'b0;
      coin.coin_insert <= '0;
      coin.coin_cents  <= '0;
    end else begin
      coin_return     <= refuse;
      fifo_count      <= count_next;
      coin.coin_valid <= (count_next != '0);
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_next;
      if (pop) begin
        if (fifo_count > CNT_ONE) begin
          coin.coin_insert <= 4'b0001 << mem[rd_next];
          coin.coin_cents  <= cents_of(mem[rd_next]);
        end else if (push) begin
          coin.coin_insert <= 4'b0001 << new_lane;
          coin.coin_cents  <= cents_of(new_lane);
        end else begin
          coin.coin_insert <= '0;
          coin.coin_cents  <= '0;
        end
      end else if (push && fifo_count == '0) begin
        coin.coin_insert <= 4'b0001 << new_lane;
        coin.coin_cents  <= cents_of(new_lane);
      end
    end
  end
endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: stimulus queues expected coins/returns,
// a negedge monitor checks every delivered coin and every return pulse.
module tb_coin_acceptor;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] coin_sense = '0;
  logic       accept_en = 1'b1;
  logic       jam_clear = 1'b0;
  logic       coin_return, jam_error;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int exp_ret = 0;
  int cents_tab[4] = '{10, 20, 50, 100};

  coin_if cif();

  coin_acceptor #(.DEBOUNCE_CYCLES(4), .JAM_CYCLES(1000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .coin_sense(coin_sense), .accept_en(accept_en),
    .jam_clear(jam_clear), .coin_return(coin_return), .jam_error(jam_error),
    .fifo_count(fifo_count), .coin(cif)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic coin(input int lane, input int hi);
    coin_sense[lane] = 1'b1;
    tick(hi);
    coin_sense[lane] = 1'b0;
    tick(14);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    cif.coin_ready = 1'b1;
    while (fifo_count != 3'd0 && n < 40) begin
      tick(1);
      n++;
    end
    check(name, fifo_count, 0);
    cif.coin_ready = 1'b0;
    tick(2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, cif.coin_valid, 0);
    check({tag, "_insert"}, cif.coin_insert, 0);
    check({tag, "_cents"}, cif.coin_cents, 0);
    check({tag, "_return"}, coin_return, 0);
    check({tag, "_jam"}, jam_error, 0);
    check({tag, "_count"}, fifo_count, 0);
  endtask

  // Monitor: every return pulse must be expected; every pop must match the queue head.
  initial begin
    int lane;
    forever begin
      @(negedge clk);
      if (reset_n && coin_return) begin
        check("return_expected", (exp_ret > 0) ? 1 : 0, 1);
        if (exp_ret > 0) exp_ret--;
      end
      if (reset_n && cif.coin_valid && cif.coin_ready) begin
        check("pop_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          lane = exp_q.pop_front();
          check("pop_insert", cif.coin_insert, 1 << lane);
          check("pop_cents", cif.coin_cents, cents_tab[lane]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    cif.coin_ready = 1'b0;
    tick(3);
    check_all_zero("reset");
    reset_n = 1'b1;
    tick(3);

    // Clean 10c pulse, latency measured from the first sampling edge
    exp_q.push_back(0);
    coin_sense[0] = 1'b1;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!cif.coin_valid && n < 20);
    check("latency_ticks", n, 7);
    check("clean_insert", cif.coin_insert, 4'b0001);
    check("clean_cents", cif.coin_cents, 10);
    check("clean_count", fifo_count, 1);
    tick(13);
    coin_sense[0] = 1'b0;
    tick(12);
    drain("clean_drain");

    // Bouncy 50c: glitch train first, then a stable press
    for (int i = 0; i < 3; i++) begin
      coin_sense[2] = 1'b1; tick(2);
      coin_sense[2] = 1'b0; tick(2);
    end
    tick(4);
    check("bounce_none", fifo_count, 0);
    exp_q.push_back(2);
    coin_sense[2] = 1'b1; tick(10);
    coin_sense[2] = 1'b0; tick(12);
    check("bounce_count", fifo_count, 1);
    check("bounce_cents", cif.coin_cents, 50);
    drain("bounce_drain");

    // Five 100c coins into a depth-4 buffer
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(3);
      else exp_ret++;
      coin(3, 8);
    end
    check("full_count", fifo_count, 4);
    check("full_ret_seen", exp_ret, 0);
    drain("full_drain");

    // Simultaneous lanes, then acceptance disabled
    exp_ret++;
    coin_sense = 4'b1001; tick(8);
    coin_sense = 4'b0000; tick(14);
    check("multi_count", fifo_count, 0);
    check("multi_ret_seen", exp_ret, 0);
    accept_en = 1'b0;
    exp_ret++;
    coin(1, 8);
    check("disabled_count", fifo_count, 0);
    check("disabled_ret_seen", exp_ret, 0);
    accept_en = 1'b1;

    // Jam on lane 1 (its first qualify is an accepted 20c coin)
    exp_q.push_back(1);
    coin_sense[1] = 1'b1;
    tick(1010);
    check("jam_set", jam_error, 1);
    exp_ret++;
    coin(2, 8);
    check("jam_ret_seen", exp_ret, 0);
    jam_clear = 1'b1; tick(1); jam_clear = 1'b0;
    tick(1);
    check("jam_hold", jam_error, 1);
    coin_sense[1] = 1'b0;
    tick(4);
    jam_clear = 1'b1; tick(1); jam_clear = 1'b0;
    tick(1);
    check("jam_cleared", jam_error, 0);
    drain("jam_drain");
    tick(10);

    // Reset mid-operation with three buffered coins and lane 0 debouncing
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(0);
      coin(0, 8);
    end
    check("pre_reset_count", fifo_count, 3);
    coin_sense[0] = 1'b1;
    tick(3);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    coin_sense[0] = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(20);
    check("post_reset_count", fifo_count, 0);
    check("post_reset_valid", cif.coin_valid, 0);

    check("queue_empty", exp_q.size(), 0);
    check("returns_done", exp_ret, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
